pla_mp2d_sweep_checker: RTL

//  Sequential harness stage wrapped around the combinational mp2d PLA: drives the PLA's 14 inputs
//  (x00..x13) and consumes its 14 outputs (z00..z13). On start it sweeps input vectors, waits a

---
 rtl/pla_mp2d_sweep_checker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pla_mp2d_sweep_checker.sv
// pla_mp2d_sweep_checker
//
// Sequential self-check harness around the combinational mp2d PLA. On start it
// applies VEC_LIMIT input vectors to the PLA, holds each vector for SETTLE+1
// cycles, samples the PLA outputs in the last cycle of that window and folds
// them into a 16-bit MISR (poly 0x1021). When the sweep ends, the signature is
// compared against golden and the result is latched into pass.
//
// Optional feature macro: PLA_SWEEP_LFSR_EN
//   defined   : vectors come from a 14-bit Fibonacci LFSR (taps 14,13,12,2),
//               seeded 14'h0001. The vector count is clamped to 16383, so the
//               all-zero vector is never applied.
//   undefined : vectors are a binary count 0,1,2,... and no LFSR is built.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high; clears all state
//   start      in   1   begins a sweep when idle (wins over abort while idle)
//   abort      in   1   ends a running sweep; no done, signature/count frozen
//   golden     in   16  expected signature, sampled on the final capture
//   z_in       in   14  PLA outputs {z13..z00}
//   x_out      out  14  PLA inputs {x13..x00}, registered
//   busy       out  1   sweep in progress
//   done       out  1   one-cycle pulse at sweep completion
//   pass       out  1   sticky: signature matched golden at last completion
//   signature  out  16  MISR contents
//   vec_count  out  15  vectors captured in the current/last sweep
module pla_mp2d_sweep_checker #(
  parameter int          SETTLE    = 2,
  parameter int          VEC_LIMIT = 16384,
  parameter logic [15:0] SIG_SEED  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] golden,
  input  logic [13:0] z_in,
  output logic [13:0] x_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [14:0] vec_count
);

`ifdef PLA_SWEEP_LFSR_EN
  // An LFSR never produces zero, so at most 16383 distinct vectors exist.
  localparam int          LIMIT     = (VEC_LIMIT > 16383) ? 16383 : VEC_LIMIT;
  localparam logic [13:0] FIRST_VEC = 14'h0001;
`else
  localparam int          LIMIT     = VEC_LIMIT;
  localparam logic [13:0] FIRST_VEC = 14'h0000;
`endif

  localparam logic [14:0] LAST_IDX = 15'(LIMIT - 1);

  // APPLY lasts SETTLE cycles and CAPTURE one more, giving SETTLE+1 per vector.
  localparam int          CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, FINISH} state_t;

  state_t        state, state_next;
  logic [CW-1:0] settle_cnt, settle_cnt_next;
  logic [13:0]   x_next;
  logic          busy_next, done_next, pass_next;
  logic [15:0]   sig_next, misr_next;
  logic [14:0]   vec_count_next;
  logic [13:0]   step_vec;

`ifdef PLA_SWEEP_LFSR_EN
  assign step_vec = {x_out[12:0], x_out[13] ^ x_out[12] ^ x_out[11] ^ x_out[1]};
`else
  assign step_vec = x_out + 14'd1;
`endif

  assign misr_next = {signature[14:0], 1'b0}
                   ^ (signature[15] ? 16'h1021 : 16'h0000)
                   ^ {2'b00, z_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      x_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      signature  <= SIG_SEED;
      vec_count  <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      x_out      <= x_next;
      busy       <= busy_next;
      done       <= done_next;
      pass       <= pass_next;
      signature  <= sig_next;
      vec_count  <= vec_count_next;
    end
  end

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    x_next          = x_out;
    busy_next       = busy;
    done_next       = 1'b0;
    pass_next       = pass;
    sig_next        = signature;
    vec_count_next  = vec_count;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_next      = APPLY;
          settle_cnt_next = '0;
          x_next          = FIRST_VEC;
          busy_next       = 1'b1;
          pass_next       = 1'b0;
          sig_next        = SIG_SEED;
          vec_count_next  = '0;
        end
      end

      APPLY: begin
        if (abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          x_next     = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_next = CAPTURE;
        end else begin
          settle_cnt_next = settle_cnt + 1'b1;
        end
      end

      CAPTURE: begin
        if (abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          x_next     = '0;
        end else begin
          sig_next       = misr_next;
          vec_count_next = vec_count + 15'd1;
          if (vec_count == LAST_IDX) begin
            // Compare the post-update signature so pass and done rise together.
            state_next = FINISH;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            x_next     = '0;
            pass_next  = (misr_next == golden);
          end else begin
            state_next      = APPLY;
            settle_cnt_next = '0;
            x_next          = step_vec;
          end
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
